// File: rtl/quad_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : quad_product_accumulator
// Brief   : Four-tap product sum: y = sum of the last four a*b products,
//           fully registered (taps, multipliers, adder tree, output).
// Revision: 1.0 - initial release
// ============================================================================
module quad_product_accumulator #(
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INPUT_WIDTH-1:0]  a,
  input  logic [INPUT_WIDTH-1:0]  b,
  output logic [OUTPUT_WIDTH-1:0] y
);

  localparam int PROD_W = 2 * INPUT_WIDTH;
  localparam int PAIR_W = PROD_W + 1;
  // Final sum is wide enough for both the full result and the output slice.
  localparam int SUM_W  = (PROD_W + 2 > OUTPUT_WIDTH) ? PROD_W + 2 : OUTPUT_WIDTH;

  logic [INPUT_WIDTH-1:0] xa [4];
  logic [INPUT_WIDTH-1:0] xb [4];
  logic [PROD_W-1:0]      p  [4];
  logic [PAIR_W-1:0]      s01;
  logic [PAIR_W-1:0]      s23;
  logic [SUM_W-1:0]       sum_all;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        xa[i] <= '0;
        xb[i] <= '0;
      end
    end else begin
      xa[0] <= a;
      xb[0] <= b;
      for (int i = 1; i < 4; i++) begin
        xa[i] <= xa[i-1];
        xb[i] <= xb[i-1];
      end
    end
  end

  // One dedicated multiplier per tap.
  for (genvar i = 0; i < 4; i++) begin : g_mul
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        p[i] <= '0;
      end else begin
        p[i] <= PROD_W'(xa[i]) * PROD_W'(xb[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s01 <= '0;
      s23 <= '0;
    end else begin
      s01 <= PAIR_W'(p[0]) + PAIR_W'(p[1]);
      s23 <= PAIR_W'(p[2]) + PAIR_W'(p[3]);
    end
  end

  assign sum_all = SUM_W'(s01) + SUM_W'(s23);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else begin
      y <= sum_all[OUTPUT_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_quad_product_accumulator
// Brief   : Directed and random checks of quad_product_accumulator against a
//           history-of-products model of the closed-form sum.
// Revision: 1.0 - initial release
// ============================================================================
module tb_quad_product_accumulator;

  localparam int IW = 14;
  localparam int OW = 28;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] a     = '0;
  logic [IW-1:0] b     = '0;
  logic [OW-1:0] y;

  int tests = 0;
  int fails = 0;

  longint hist[$];  // products captured since reset, newest first

  quad_product_accumulator #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .y    (y)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
    end else begin
      hist.push_front(longint'(a) * longint'(b));
      if (hist.size() > 7) void'(hist.pop_back());
    end
  end

  function automatic logic [OW-1:0] model_y();
    longint s = 0;
    if (reset) return '0;
    for (int j = 3; j <= 6; j++)
      if (j < hist.size()) s += hist[j];
    return OW'(s);
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] exp);
    tests++;
    assert (y === exp) else begin
      fails++;
      $error("FAIL %s: y=%0d expected=%0d", tag, y, exp);
    end
  endtask

  // Apply (av, bv) for n edges, comparing against the model after each.
  task automatic hold(input logic [IW-1:0] av, input logic [IW-1:0] bv,
                      input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      a = av;
      b = bv;
      @(negedge clk);
      check(tag, model_y());
    end
  endtask

  initial begin
    // Reset held with random inputs on a running clock.
    for (int i = 0; i < 4; i++) begin
      a = IW'($urandom);
      b = IW'($urandom);
      @(negedge clk);
      check("reset_hold", '0);
    end
    reset = 1'b0;
    a = '0;
    b = '0;
    hold('0, '0, 8, "release_zero");
    check("release_zero_const", '0);

    hold(14'd1, 14'd2, 7, "steady_1x2");
    check("steady_1x2_const", 28'd8);
    hold(14'd2, 14'd5, 7, "steady_2x5");
    check("steady_2x5_const", 28'd40);
    hold(14'd3, 14'd5, 7, "steady_3x5");
    check("steady_3x5_const", 28'd60);

    hold(14'h3FFF, 14'h3FFF, 7, "wrap");
    check("wrap_const", 28'd268304388);

    // Impulse: one sample, then zeros; visible after edges k+3..k+6.
    hold('0, '0, 7, "impulse_flush");
    hold(14'd1, 14'd1, 1, "impulse_k");
    check("impulse_k_const", '0);
    for (int i = 1; i <= 7; i++) begin
      hold('0, '0, 1, "impulse_tail");
      check("impulse_tail_const", (i >= 3 && i <= 6) ? 28'd1 : 28'd0);
    end

    // Asynchronous reset mid-stream, then refill.
    hold(14'd5, 14'd7, 6, "stream");
    #2 reset = 1'b1;
    #1 check("async_reset", '0);
    @(negedge clk);
    check("async_reset_held", '0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hold(14'd3, 14'd4, 1, "refill");
      check("refill_zero", '0);
    end
    hold(14'd3, 14'd4, 1, "refill");
    check("refill_first", 28'd12);
    hold(14'd3, 14'd4, 1, "refill");
    check("refill_second", 28'd24);

    for (int i = 0; i < 1200; i++)
      hold(IW'($urandom), IW'($urandom), 1, "random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
